// File: rtl/pc_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_trace_pkg
// Purpose : Shared constants and state enumeration for the PC trace buffer.
//           Holds the default history depth, pointer width, PC width and
//           the two-state recorder enumeration.
// Revision: 1.0 - initial release
// ============================================================================
package pc_trace_pkg;

    localparam int c_DEFAULT_DEPTH  = 16;
    localparam int c_DEFAULT_ADDR_W = 4;
    localparam int c_PC_W           = 32;

    // Recorder state: capturing retired PCs, or halted for host readout.
    typedef enum logic [0:0] {
        ST_RECORD = 1'b0,
        ST_FROZEN = 1'b1
    } trace_state_e;

endpackage : pc_trace_pkg
`default_nettype wire

// File: rtl/pc_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_trace_buffer_if
// Purpose : Bundles the core/host facing signals of the PC trace buffer.
//   pc_valid, pc_in    : retire strobe and retiring PC from the core
//   freeze, pop, clear : debug-halt level, readout advance level, clear
//   pc_out, count      : registered PC view and number of valid entries
//   overflow, frozen   : sticky overwrite flag and frozen-state indicator
//   master modport drives the inputs, slave modport is the buffer side.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_trace_buffer_if
    import pc_trace_pkg::*;
#(
    parameter int ADDR_W = c_DEFAULT_ADDR_W
) ();

    logic                pc_valid;
    logic [c_PC_W-1:0]   pc_in;
    logic                freeze;
    logic                pop;
    logic                clear;
    logic [c_PC_W-1:0]   pc_out;
    logic [ADDR_W:0]     count;
    logic                overflow;
    logic                frozen;

    modport master (
        output pc_valid, pc_in, freeze, pop, clear,
        input  pc_out, count, overflow, frozen
    );

    modport slave (
        input  pc_valid, pc_in, freeze, pop, clear,
        output pc_out, count, overflow, frozen
    );

endinterface : pc_trace_buffer_if
`default_nettype wire

// File: rtl/pc_trace_ram.sv
`default_nettype none
// ============================================================================
// Module  : pc_trace_ram
// Purpose : Simple dual-port storage for the PC history. One synchronous
//           write port, one read port with a registered output. Contents
//           are not reset; validity is tracked by the owner.
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address, sampled on the rising edge
//   o_rd_data : registered read data
// Revision: 1.0 - initial release
// ============================================================================
module pc_trace_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule : pc_trace_ram
`default_nettype wire

// File: rtl/pc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : pc_trace_buffer
// Purpose : Circular history of retired program counters. While recording,
//           every retire strobe is captured and pc_out tracks the live PC.
//           While frozen, the history is walked newest-first, one entry per
//           rising edge of the host pop level.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : pc_trace_buffer_if.slave (pc_valid, pc_in, freeze, pop, clear
//           in; pc_out, count, overflow, frozen out)
// Revision: 1.0 - initial release
// ============================================================================
module pc_trace_buffer
    import pc_trace_pkg::*;
#(
    parameter int DEPTH  = c_DEFAULT_DEPTH,
    parameter int ADDR_W = c_DEFAULT_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_trace_buffer_if.slave        bus
);

    localparam logic [ADDR_W:0]   c_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    trace_state_e        r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic                r_frozen;
    logic                r_pop_d;
    logic                r_adv_d;
    logic [c_PC_W-1:0]   r_pc_out;

    logic                w_pop_rise;
    logic                w_adv;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [c_PC_W-1:0]   w_ram_q;

    assign w_pop_rise = bus.pop & ~r_pop_d;

    // A readout advance happens only while staying frozen with entries left.
    assign w_adv = (r_state == ST_FROZEN) & bus.freeze & ~bus.clear &
                   w_pop_rise & (r_count != '0);

    assign w_wr_en = (r_state == ST_RECORD) & bus.pc_valid & ~bus.clear;

    // Read ahead with the post-advance pointer so the RAM output is ready one
    // edge after the advance and pc_out can be reloaded on the following edge.
    assign w_rd_addr = w_adv ? (r_rd_ptr - c_PTR_ONE) : r_rd_ptr;

    pc_trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (c_PC_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.pc_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RECORD;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_frozen   <= 1'b0;
            r_pop_d    <= 1'b0;
            r_adv_d    <= 1'b0;
            r_pc_out   <= '0;
        end else begin
            // The edge detector always follows pop so a level held across a
            // clear or a state change never looks like a fresh edge.
            r_pop_d <= bus.pop;
            r_adv_d <= 1'b0;

            if (bus.clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_pc_out   <= '0;
            end else begin
                case (r_state)
                    ST_RECORD: begin
                        if (bus.pc_valid) begin
                            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                            r_pc_out <= bus.pc_in;
                            if (r_count == c_FULL) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_count <= r_count + c_CNT_ONE;
                            end
                        end
                        if (bus.freeze) begin
                            r_state  <= ST_FROZEN;
                            r_frozen <= 1'b1;
                            // A capture on this same edge becomes the newest entry.
                            r_rd_ptr <= bus.pc_valid ? r_wr_ptr : (r_wr_ptr - c_PTR_ONE);
                            if (!bus.pc_valid && (r_count == '0)) begin
                                r_pc_out <= '0;
                            end
                        end
                    end

                    ST_FROZEN: begin
                        if (!bus.freeze) begin
                            r_state    <= ST_RECORD;
                            r_frozen   <= 1'b0;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                        end else begin
                            if (w_adv) begin
                                r_rd_ptr <= r_rd_ptr - c_PTR_ONE;
                                r_count  <= r_count - c_CNT_ONE;
                                r_adv_d  <= 1'b1;
                            end
                            // RAM output now holds the entry selected by the
                            // previous advance; an emptied buffer reads as zero.
                            if (r_adv_d) begin
                                r_pc_out <= (r_count == '0) ? '0 : w_ram_q;
                            end
                        end
                    end

                    default: begin
                        r_state  <= ST_RECORD;
                        r_frozen <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pc_out   = r_pc_out;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.frozen   = r_frozen;

endmodule : pc_trace_buffer
`default_nettype wire
